// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for a single-cycle core's data port. Read data is
// combinational from the address so the core's writeback mux can consume it
// in the same cycle. Writes commit at the rising edge.
//
// Address map (byte addresses, bits [1:0] ignored, word access only):
//   0 .. 4*RAM_WORDS-1   word RAM (not cleared by reset)
//   IO_BASE + 0x0        TXDATA  : write pushes wdata[7:0], reads as 0
//   IO_BASE + 0x4        STATUS  : {29'b0, ovf, full, empty}, write bit2=1 clears ovf
//   IO_BASE + 0x8        CYCLES  : free-running counter, write loads it
//   anything else        unmapped: reads 0, writes ignored, sets err_unmapped
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   mem_we        write strobe from core
//   mem_addr      byte address from core
//   mem_wdata     write data from core
//   mem_rdata     combinational read data to core
//   tx_data       head byte of TX FIFO (0 when empty)
//   tx_valid      TX FIFO non-empty
//   tx_ready      downstream accepts tx_data this cycle
//   err_unmapped  sticky flag: an unmapped address was presented
// ----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int unsigned RAM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] IO_BASE    = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        err_unmapped
);

    localparam int unsigned IDX_W = $clog2(RAM_WORDS);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [31:0]  RAM_BYTES   = 32'(4 * RAM_WORDS);
    localparam logic [29:0]  TX_WORD     = IO_BASE[31:2];
    localparam logic [29:0]  STATUS_WORD = TX_WORD + 30'd1;
    localparam logic [29:0]  CYCLES_WORD = TX_WORD + 30'd2;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_TX,
        SEL_STATUS,
        SEL_CYCLES,
        SEL_NONE
    } sel_e;

    // Storage
    logic [31:0]      r_ram  [RAM_WORDS];
    logic [7:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_ovf;
    logic             r_err;
    logic [31:0]      r_cycles;

    // Decode and FIFO handshake
    sel_e             w_sel;
    logic [IDX_W-1:0] w_ram_idx;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_push_ok;

    assign w_ram_idx = mem_addr[IDX_W+1:2];

    // NOTE: every always_comb output gets a default before any branch so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        w_sel = SEL_NONE;
        if (mem_addr < RAM_BYTES) begin
            w_sel = SEL_RAM;
        end else if (mem_addr[31:2] == TX_WORD) begin
            w_sel = SEL_TX;
        end else if (mem_addr[31:2] == STATUS_WORD) begin
            w_sel = SEL_STATUS;
        end else if (mem_addr[31:2] == CYCLES_WORD) begin
            w_sel = SEL_CYCLES;
        end
    end

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_COUNT);
    assign w_pop     = !w_empty && tx_ready;
    assign w_push    = mem_we && (w_sel == SEL_TX);
    // A full FIFO still takes the byte when the head leaves in the same edge.
    assign w_push_ok = w_push && (!w_full || w_pop);

    assign tx_valid     = !w_empty;
    // Entry storage is never cleared, so mask the head while empty.
    assign tx_data      = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
    assign err_unmapped = r_err;

    // Reads reflect pre-edge state; TXDATA and unmapped fall to zero.
    always_comb begin
        mem_rdata = '0;
        case (w_sel)
            SEL_RAM:    mem_rdata = r_ram[w_ram_idx];
            SEL_STATUS: mem_rdata = {29'b0, r_ovf, w_full, w_empty};
            SEL_CYCLES: mem_rdata = r_cycles;
            default:    mem_rdata = '0;
        endcase
    end

    // NOTE: RAM and FIFO entry arrays carry no reset so they can map onto
    // memory primitives; only the pointers/count define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && mem_we && (w_sel == SEL_RAM)) begin
            r_ram[w_ram_idx] <= mem_wdata;
        end
        if (!reset && w_push_ok) begin
            r_fifo[r_wr_ptr] <= mem_wdata[7:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_cycles <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end

            // Simultaneous push and pop leaves the occupancy unchanged.
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + (PTR_W + 1)'(1);
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - (PTR_W + 1)'(1);
            end

            if (w_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end else if (mem_we && (w_sel == SEL_STATUS) && mem_wdata[2]) begin
                r_ovf <= 1'b0;
            end

            if (w_sel == SEL_NONE) begin
                r_err <= 1'b1;
            end

            // A load wins over the increment on the same edge.
            if (mem_we && (w_sel == SEL_CYCLES)) begin
                r_cycles <= mem_wdata;
            end else begin
                r_cycles <= r_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Self-checking bench for data_mem_responder. A behavioural model (word
// array, byte queue, flags, counter) is advanced once per clock edge from the
// same inputs the DUT sees; outputs are compared 1-2 time units after the
// rising edge, well away from it.
// ----------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int          RAM_WORDS  = 64;
    localparam int          FIFO_DEPTH = 8;
    localparam logic [31:0] IO_BASE    = 32'h0000_1000;
    localparam logic [31:0] TX_A       = IO_BASE;
    localparam logic [31:0] ST_A       = IO_BASE + 32'h4;
    localparam logic [31:0] CY_A       = IO_BASE + 32'h8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = CY_A;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        err_unmapped;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [31:0] m_ram [RAM_WORDS];
    logic [7:0]  m_q [$];
    logic        m_ovf = 1'b0;
    logic        m_err = 1'b0;
    logic [31:0] m_cyc = '0;

    data_mem_responder #(
        .RAM_WORDS (RAM_WORDS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .IO_BASE   (IO_BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .err_unmapped(err_unmapped)
    );

    always #10 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [5:0] idx;
        idx = a[7:2];
        if (a < 32'(4 * RAM_WORDS)) return m_ram[idx];
        if (a[31:2] == TX_A[31:2])  return 32'h0;
        if (a[31:2] == ST_A[31:2])
            return {29'b0, m_ovf, (m_q.size() == FIFO_DEPTH), (m_q.size() == 0)};
        if (a[31:2] == CY_A[31:2])  return m_cyc;
        return 32'h0;
    endfunction

    function automatic logic [7:0] model_head();
        if (m_q.size() == 0) return 8'h00;
        return m_q[0];
    endfunction

    // Advance the model by one rising edge using the current inputs.
    function automatic void model_edge();
        logic       is_ram, is_tx, is_st, is_cy, pop;
        logic [5:0] idx;
        int         occ;
        is_ram = mem_addr < 32'(4 * RAM_WORDS);
        is_tx  = mem_addr[31:2] == TX_A[31:2];
        is_st  = mem_addr[31:2] == ST_A[31:2];
        is_cy  = mem_addr[31:2] == CY_A[31:2];
        idx    = mem_addr[7:2];
        if (reset) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_err = 1'b0;
            m_cyc = '0;
            return;
        end
        if (!(is_ram || is_tx || is_st || is_cy)) m_err = 1'b1;
        occ = m_q.size();
        pop = (occ != 0) && tx_ready;
        if (pop) void'(m_q.pop_front());
        if (mem_we && is_ram) m_ram[idx] = mem_wdata;
        if (mem_we && is_tx) begin
            if (occ < FIFO_DEPTH || pop) m_q.push_back(mem_wdata[7:0]);
            else                         m_ovf = 1'b1;
        end
        if (mem_we && is_st && mem_wdata[2]) m_ovf = 1'b0;
        if (mem_we && is_cy) m_cyc = mem_wdata;
        else                 m_cyc = m_cyc + 32'd1;
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        mem_addr = CY_A;
        #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_tx_valid got=%0b exp=0", tx_valid); end
        n_checks++; if (tx_data !== 8'h00) begin n_errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        n_checks++; if (err_unmapped !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%0b exp=0", err_unmapped); end
        n_checks++; if (mem_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_cycles got=%h exp=0", mem_rdata); end
        mem_addr = ST_A;
        #1;
        n_checks++; if (mem_rdata !== 32'h1) begin n_errors++; $display("FAIL reset_status got=%h exp=1", mem_rdata); end
        mem_addr = CY_A;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++; if (mem_rdata !== 32'(k)) begin n_errors++; $display("FAIL cycles_count got=%h exp=%h", mem_rdata, 32'(k)); end
        end
    endtask

    task automatic test_ram();
        logic [31:0] old_val;
        for (int i = 0; i < RAM_WORDS; i++) begin
            mem_we    = 1'b1;
            mem_addr  = 32'(i * 4) + 32'($urandom_range(0, 3));
            mem_wdata = $urandom;
            tick();
        end
        mem_we    = 1'b1;
        mem_addr  = 32'h10;
        mem_wdata = 32'hDEAD_BEEF;
        old_val   = model_read(32'h10);
        #1;
        n_checks++; if (mem_rdata !== old_val) begin n_errors++; $display("FAIL ram_same_cycle got=%h exp=%h", mem_rdata, old_val); end
        tick();
        mem_we = 1'b0;
        #1;
        n_checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL ram_read_10 got=%h exp=deadbeef", mem_rdata); end
        mem_addr = 32'h13;
        #1;
        n_checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL ram_read_13 got=%h exp=deadbeef", mem_rdata); end
        for (int i = 0; i < 8; i++) begin
            mem_addr = 32'($urandom_range(0, 4 * RAM_WORDS - 1));
            #1;
            n_checks++; if (mem_rdata !== model_read(mem_addr)) begin n_errors++; $display("FAIL ram_rand addr=%h got=%h exp=%h", mem_addr, mem_rdata, model_read(mem_addr)); end
            tick();
        end
    endtask

    task automatic test_tx_order();
        logic [7:0] seq [3];
        seq[0] = 8'h41; seq[1] = 8'h42; seq[2] = 8'h43;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_we    = 1'b1;
            mem_addr  = TX_A;
            mem_wdata = {24'($urandom), seq[i]};
            tick();
        end
        mem_we   = 1'b0;
        mem_addr = ST_A;
        #1;
        n_checks++; if (tx_valid !== 1'b1) begin n_errors++; $display("FAIL tx_valid_after_push got=%0b exp=1", tx_valid); end
        n_checks++; if (tx_data !== 8'h41) begin n_errors++; $display("FAIL tx_head got=%h exp=41", tx_data); end
        tick();
        tick();
        n_checks++; if (tx_data !== 8'h41 || tx_valid !== 1'b1) begin n_errors++; $display("FAIL tx_hold got=%h/%0b exp=41/1", tx_data, tx_valid); end
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (tx_data !== seq[i] || tx_valid !== 1'b1) begin n_errors++; $display("FAIL tx_order[%0d] got=%h exp=%h", i, tx_data, seq[i]); end
            tick();
        end
        tx_ready = 1'b0;
        n_checks++; if (tx_valid !== 1'b0) begin n_errors++; $display("FAIL tx_drained got=%0b exp=0", tx_valid); end
        n_checks++; if (mem_rdata !== 32'h1) begin n_errors++; $display("FAIL tx_status_empty got=%h exp=1", mem_rdata); end
    endtask

    task automatic test_overflow();
        logic [7:0] pushed [9];
        logic [7:0] extra;
        logic [7:0] exp_order [8];
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            mem_we    = 1'b1;
            mem_addr  = TX_A;
            mem_wdata = $urandom;
            pushed[i] = mem_wdata[7:0];
            tick();
        end
        mem_we   = 1'b0;
        mem_addr = ST_A;
        #1;
        n_checks++; if (mem_rdata !== 32'h6) begin n_errors++; $display("FAIL ovf_status got=%h exp=6", mem_rdata); end
        n_checks++; if (tx_data !== pushed[0]) begin n_errors++; $display("FAIL ovf_head got=%h exp=%h", tx_data, pushed[0]); end
        // Full FIFO: pop and push on the same edge.
        mem_we    = 1'b1;
        mem_addr  = TX_A;
        mem_wdata = $urandom;
        extra     = mem_wdata[7:0];
        tx_ready  = 1'b1;
        tick();
        mem_we   = 1'b0;
        tx_ready = 1'b0;
        mem_addr = ST_A;
        #1;
        n_checks++; if (mem_rdata !== 32'h6) begin n_errors++; $display("FAIL full_pop_push_status got=%h exp=6", mem_rdata); end
        mem_we    = 1'b1;
        mem_wdata = 32'h4;
        tick();
        mem_we = 1'b0;
        #1;
        n_checks++; if (mem_rdata !== 32'h2) begin n_errors++; $display("FAIL ovf_clear got=%h exp=2", mem_rdata); end
        for (int i = 0; i < 7; i++) exp_order[i] = pushed[i + 1];
        exp_order[7] = extra;
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (tx_data !== exp_order[i] || tx_valid !== 1'b1) begin n_errors++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, tx_data, exp_order[i]); end
            tick();
        end
        tx_ready = 1'b0;
        n_checks++; if (tx_valid !== 1'b0) begin n_errors++; $display("FAIL ovf_drained got=%0b exp=0", tx_valid); end
    endtask

    task automatic test_cycles();
        mem_we    = 1'b1;
        mem_addr  = CY_A;
        mem_wdata = 32'hFFFF_FFFE;
        tick();
        mem_we = 1'b0;
        #1;
        n_checks++; if (mem_rdata !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL cyc_load got=%h exp=fffffffe", mem_rdata); end
        tick();
        n_checks++; if (mem_rdata !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL cyc_max got=%h exp=ffffffff", mem_rdata); end
        tick();
        n_checks++; if (mem_rdata !== 32'h0) begin n_errors++; $display("FAIL cyc_wrap got=%h exp=0", mem_rdata); end
        tick();
        n_checks++; if (mem_rdata !== 32'h1) begin n_errors++; $display("FAIL cyc_resume got=%h exp=1", mem_rdata); end
    endtask

    task automatic test_unmapped();
        logic [31:0] exp_status;
        mem_addr = 32'h800;
        #1;
        n_checks++; if (mem_rdata !== 32'h0) begin n_errors++; $display("FAIL unmapped_rdata got=%h exp=0", mem_rdata); end
        n_checks++; if (err_unmapped !== 1'b0) begin n_errors++; $display("FAIL unmapped_err_early got=%0b exp=0", err_unmapped); end
        tick();
        mem_addr = CY_A;
        #1;
        n_checks++; if (err_unmapped !== 1'b1) begin n_errors++; $display("FAIL unmapped_err got=%0b exp=1", err_unmapped); end
        exp_status = model_read(ST_A);
        mem_we    = 1'b1;
        mem_addr  = IO_BASE + 32'hC;
        mem_wdata = $urandom;
        tick();
        mem_we   = 1'b0;
        mem_addr = ST_A;
        #1;
        n_checks++; if (mem_rdata !== exp_status) begin n_errors++; $display("FAIL unmapped_wr_status got=%h exp=%h", mem_rdata, exp_status); end
        mem_addr = CY_A;
        #1;
        n_checks++; if (mem_rdata !== m_cyc) begin n_errors++; $display("FAIL unmapped_wr_cycles got=%h exp=%h", mem_rdata, m_cyc); end
        n_checks++; if (tx_valid !== 1'b0) begin n_errors++; $display("FAIL unmapped_wr_tx got=%0b exp=0", tx_valid); end
    endtask

    task automatic test_reset_midstream();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_we    = 1'b1;
            mem_addr  = TX_A;
            mem_wdata = $urandom;
            tick();
        end
        mem_we   = 1'b0;
        mem_addr = ST_A;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_errors++; $display("FAIL midrst_tx got=%h/%0b exp=00/0", tx_data, tx_valid); end
        n_checks++; if (mem_rdata !== 32'h1) begin n_errors++; $display("FAIL midrst_status got=%h exp=1", mem_rdata); end
        n_checks++; if (err_unmapped !== 1'b0) begin n_errors++; $display("FAIL midrst_err got=%0b exp=0", err_unmapped); end
        mem_addr = CY_A;
        #1;
        n_checks++; if (mem_rdata !== 32'h0) begin n_errors++; $display("FAIL midrst_cycles got=%h exp=0", mem_rdata); end
        tick();
        mem_addr = 32'h10;
        #1;
        n_checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL midrst_ram got=%h exp=deadbeef", mem_rdata); end
    endtask

    task automatic test_random();
        int sel;
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 19);
            if (sel < 8)       mem_addr = 32'($urandom_range(0, 4 * RAM_WORDS - 1));
            else if (sel < 13) mem_addr = TX_A + 32'($urandom_range(0, 3));
            else if (sel < 16) mem_addr = ST_A;
            else if (sel < 18) mem_addr = CY_A;
            else if (sel < 19) mem_addr = IO_BASE + 32'hC;
            else               mem_addr = $urandom;
            mem_we    = ($urandom_range(0, 2) != 0);
            mem_wdata = $urandom;
            tx_ready  = ($urandom_range(0, 2) == 0);
            #1;
            n_checks++;
            if (mem_rdata !== model_read(mem_addr) || tx_valid !== (m_q.size() != 0) ||
                tx_data !== model_head() || err_unmapped !== m_err) begin
                n_errors++;
                $display("FAIL rand[%0d] addr=%h rdata=%h/%h valid=%0b data=%h/%h err=%0b/%0b",
                         n, mem_addr, mem_rdata, model_read(mem_addr), tx_valid,
                         tx_data, model_head(), err_unmapped, m_err);
            end
            tick();
        end
        mem_we   = 1'b0;
        tx_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ram();
        test_tx_order();
        test_overflow();
        test_cycles();
        test_unmapped();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: run did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
